// File: rtl/data_sync_ctrl.sv
// data_sync_ctrl
// Destination-domain side of a 4-phase REQ/ACK multi-bit clock-domain crossing.
// The source request level is synchronized through a NUM_STAGES flop chain.
// The source bus is captured once per handshake and offered on a valid/ready port.
// ACK is returned to the source once the consumer has taken the word.
// ACK is dropped again when the synchronized request has returned to zero.

module data_sync_ctrl #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 UNSYNC_REQ,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 SYNC_READY,
  input  logic                 ERR_CLR,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 SYNC_VALID,
  output logic                 ACK,
  output logic                 BUSY,
  output logic                 ERR
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t                 state_q;
  logic [NUM_STAGES-1:0]  sync_q;
  logic [NUM_STAGES-1:0]  sync_d;
  logic                   req_s;
  logic [BUS_WIDTH-1:0]   bus_q;
  logic                   valid_q;
  logic                   ack_q;
  logic                   err_q;

  // Next value of the request synchronizer: shift the raw request in at bit 0.
  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], UNSYNC_REQ};
  end

  // Request synchronizer chain; the raw request is touched nowhere else.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign req_s = sync_q[NUM_STAGES-1];

  // Handshake FSM with registered data, valid, acknowledge and error outputs.
  // ERR_CLR is applied first so that a withdraw event in the same cycle wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      bus_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (ERR_CLR) begin
        err_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          // Capture only on a fresh request seen from IDLE.
          if (req_s) begin
            bus_q   <= UNSYNC_BUS;
            valid_q <= 1'b1;
            state_q <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (!req_s) begin
            // Source withdrew before the word was consumed; keep the stale bus.
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (SYNC_READY) begin
            valid_q <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          // Wait for the return-to-zero phase; no recapture in this state.
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a quiet IDLE.
          valid_q <= 1'b0;
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign SYNC_BUS   = bus_q;
  assign SYNC_VALID = valid_q;
  assign ACK        = ack_q;
  assign ERR        = err_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_sync_ctrl.sv
// Self-checking bench for data_sync_ctrl (NUM_STAGES=2, BUS_WIDTH=8).
module tb_data_sync_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       UNSYNC_REQ = 1'b0;
  logic [7:0] UNSYNC_BUS = 8'h00;
  logic       SYNC_READY = 1'b0;
  logic       ERR_CLR = 1'b0;
  logic [7:0] SYNC_BUS;
  logic       SYNC_VALID;
  logic       ACK;
  logic       BUSY;
  logic       ERR;

  int checks = 0;
  int errors = 0;

  data_sync_ctrl #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .UNSYNC_REQ(UNSYNC_REQ), .UNSYNC_BUS(UNSYNC_BUS),
    .SYNC_READY(SYNC_READY), .ERR_CLR(ERR_CLR), .SYNC_BUS(SYNC_BUS),
    .SYNC_VALID(SYNC_VALID), .ACK(ACK), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       req;
    logic [7:0] bus;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic       e_ack;
    logic       e_busy;
    logic       e_err;
    logic [7:0] e_bus;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) for ACK to reach val; the final compare flags a timeout.
  task automatic wait_ack(input string name, input logic val, input int budget);
    for (int i = 0; i < budget && ACK !== val; i++) step();
    chk(name, {31'd0, ACK}, {31'd0, val});
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && SYNC_VALID !== 1'b1; i++) step();
    chk(name, {31'd0, SYNC_VALID}, 32'd1);
  endtask

  // Random-traffic state
  logic [7:0] words[24];
  logic [7:0] exp_q[$];
  int         tx;
  int         rx;
  int         phase;
  int         gap;
  logic       prev_hold;
  logic [7:0] prev_bus;
  logic       xfer;

  initial begin
    // Reset
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", {31'd0, SYNC_VALID}, 32'd0);
    chk("rst_ack",   {31'd0, ACK}, 32'd0);
    chk("rst_busy",  {31'd0, BUSY}, 32'd0);
    chk("rst_err",   {31'd0, ERR}, 32'd0);
    chk("rst_bus",   {24'd0, SYNC_BUS}, 32'd0);
    RST = 1'b1;

    // Table: basic transfer with latency, early withdraw + clear, set-over-clear priority.
    //           req  bus    rdy  clr   valid ack  busy err  bus
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[3]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[4]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[5]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[6]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[8]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[9]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[10] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[11] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[12] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[13] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C};
    vecs[14] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[16] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[17] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[18] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77};
    vecs[19] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77};
    vecs[20] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77};
    vecs[21] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77};
    vecs[22] = '{1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77};
    vecs[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77};

    for (int v = 0; v < 24; v++) begin
      UNSYNC_REQ = vecs[v].req;
      UNSYNC_BUS = vecs[v].bus;
      SYNC_READY = vecs[v].rdy;
      ERR_CLR    = vecs[v].clr;
      step();
      chk($sformatf("vec%0d_valid", v), {31'd0, SYNC_VALID}, {31'd0, vecs[v].e_valid});
      chk($sformatf("vec%0d_ack", v),   {31'd0, ACK},        {31'd0, vecs[v].e_ack});
      chk($sformatf("vec%0d_busy", v),  {31'd0, BUSY},       {31'd0, vecs[v].e_busy});
      chk($sformatf("vec%0d_err", v),   {31'd0, ERR},        {31'd0, vecs[v].e_err});
      chk($sformatf("vec%0d_bus", v),   {24'd0, SYNC_BUS},   {24'd0, vecs[v].e_bus});
    end

    // Backpressure: READY low for 10 cycles after VALID rises.
    UNSYNC_BUS = 8'h3C; UNSYNC_REQ = 1'b1; SYNC_READY = 1'b0; ERR_CLR = 1'b0;
    wait_valid("bp_valid_rise", 10);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", {31'd0, SYNC_VALID}, 32'd1);
      chk("bp_hold_bus", {24'd0, SYNC_BUS}, 32'h3C);
      chk("bp_hold_ack", {31'd0, ACK}, 32'd0);
    end
    SYNC_READY = 1'b1;
    step();
    chk("bp_ack_after_ready", {31'd0, ACK}, 32'd1);
    chk("bp_valid_after_ready", {31'd0, SYNC_VALID}, 32'd0);
    UNSYNC_REQ = 1'b0;
    wait_ack("bp_ack_fall", 1'b0, 10);
    chk("bp_busy_idle", {31'd0, BUSY}, 32'd0);

    // Request held high through ACK while the bus changes: one capture only.
    begin
      int vcount;
      vcount = 0;
      UNSYNC_BUS = 8'h11; UNSYNC_REQ = 1'b1; SYNC_READY = 1'b1;
      for (int i = 0; i < 12; i++) begin
        if (i == 3) UNSYNC_BUS = 8'h22;
        step();
        if (SYNC_VALID) vcount++;
      end
      chk("hold_one_pulse", vcount, 32'd1);
      chk("hold_bus", {24'd0, SYNC_BUS}, 32'h11);
      chk("hold_ack", {31'd0, ACK}, 32'd1);
      UNSYNC_REQ = 1'b0;
      wait_ack("hold_ack_fall", 1'b0, 10);
    end

    // Reset asserted in ACK aborts immediately; fresh capture afterwards.
    UNSYNC_BUS = 8'h99; UNSYNC_REQ = 1'b1; SYNC_READY = 1'b1;
    wait_ack("rstmid_ack", 1'b1, 10);
    #2 RST = 1'b0;
    #1;
    chk("rstmid_ack0", {31'd0, ACK}, 32'd0);
    chk("rstmid_valid0", {31'd0, SYNC_VALID}, 32'd0);
    chk("rstmid_bus0", {24'd0, SYNC_BUS}, 32'd0);
    chk("rstmid_busy0", {31'd0, BUSY}, 32'd0);
    UNSYNC_BUS = 8'h5A; SYNC_READY = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    step();
    wait_valid("rstmid_recapture", 10);
    chk("rstmid_bus5a", {24'd0, SYNC_BUS}, 32'h5A);
    SYNC_READY = 1'b1;
    wait_ack("rstmid_ack_again", 1'b1, 10);
    UNSYNC_REQ = 1'b0;
    wait_ack("rstmid_ack_fall", 1'b0, 10);

    // Random back-to-back 4-phase transfers against an in-order scoreboard.
    for (int i = 0; i < 8; i++) words[i] = 8'(i + 1);
    for (int i = 8; i < 24; i++) words[i] = 8'($urandom);
    tx = 0; rx = 0; phase = 0; gap = 0; prev_hold = 1'b0; prev_bus = 8'h00;
    for (int cyc = 0; cyc < 4000 && tx < 24; cyc++) begin
      SYNC_READY = ($urandom_range(0, 2) == 0);
      xfer = SYNC_VALID && SYNC_READY;
      if (prev_hold) begin
        chk("rnd_stall_valid", {31'd0, SYNC_VALID}, 32'd1);
        chk("rnd_stall_bus", {24'd0, SYNC_BUS}, {24'd0, prev_bus});
      end
      if (xfer) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra_word", 32'd1, 32'd0);
        end else begin
          chk($sformatf("rnd_word%0d", rx), {24'd0, SYNC_BUS}, {24'd0, exp_q.pop_front()});
          rx++;
        end
      end
      prev_hold = SYNC_VALID && !SYNC_READY;
      prev_bus  = SYNC_BUS;
      case (phase)
        0: begin
          if (gap > 0) gap--;
          else begin
            UNSYNC_BUS = words[tx];
            exp_q.push_back(words[tx]);
            UNSYNC_REQ = 1'b1;
            phase = 1;
          end
        end
        1: begin
          if (ACK) begin
            UNSYNC_REQ = 1'b0;
            phase = 2;
          end
        end
        default: begin
          if (!ACK) begin
            tx++;
            gap = $urandom_range(0, 3);
            phase = 0;
          end
        end
      endcase
      step();
    end
    chk("rnd_all_sent", tx, 32'd24);
    chk("rnd_all_received", rx, 32'd24);
    chk("rnd_err_clear", {31'd0, ERR}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
